imem_bank_xbar: RTL and testbench

Parametrised crossbar between N instruction-fetch cores and M word-interleaved instruction-memory banks. Each bank has its own round-robin arbiter. The granted core's address is steered to the bank, and the bank's read data comes back one cycle later to the core that was granted. This generalises the fixed 3-core, one-hot bank-to-core grant routing, and adds fairness, parallel access to distinct banks, and registered response routing.

---
 rtl/imem_xbar_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/imem_bank_xbar.sv | 109 ++++++++++
 tb/tb_imem_bank_xbar.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_xbar_pkg.sv
// rtl/imem_xbar_pkg.sv - default geometry, types and address helpers for the imem bank crossbar
package imem_xbar_pkg;

  localparam int DEF_N_CORES = 3;
  localparam int DEF_N_BANKS = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;

  localparam int BIDX_W  = $clog2(DEF_N_BANKS);
  localparam int BANK_AW = DEF_ADDR_W - 2 - BIDX_W;
  localparam int CID_W   = $clog2(DEF_N_CORES);

  typedef logic [CID_W-1:0] core_id_t;

  typedef struct packed {
    logic     vld;
    core_id_t id;
  } resp_tag_t;

  // Word-interleaved: the bank index sits just above the byte offset.
  function automatic logic [BIDX_W-1:0] bank_idx_f(input logic [DEF_ADDR_W-1:0] addr);
    return BIDX_W'(addr >> 2);
  endfunction

  function automatic logic [BANK_AW-1:0] bank_waddr_f(input logic [DEF_ADDR_W-1:0] addr);
    return BANK_AW'(addr >> (2 + BIDX_W));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with a rotating priority pointer
module rr_arbiter
  import imem_xbar_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  logic [IDW-1:0] ptr;
  logic           found;

  // Scan from ptr upward, wrapping; the first active requester wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found                      = 1'b1;
        gnt[(int'(ptr) + i) % N]   = 1'b1;
        gnt_id                     = IDW'((int'(ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|req) begin
      ptr <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/imem_bank_xbar.sv
// rtl/imem_bank_xbar.sv - N-core to M-bank instruction fetch crossbar with per-bank round-robin
module imem_bank_xbar
  import imem_xbar_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int N_BANKS = DEF_N_BANKS,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  localparam int BIDX_W  = $clog2(N_BANKS),
  localparam int BANK_AW = ADDR_W - 2 - BIDX_W,
  localparam int CID_W   = $clog2(N_CORES)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_CORES-1:0]                core_req,
  input  logic [N_CORES-1:0][ADDR_W-1:0]    core_addr,
  output logic [N_CORES-1:0]                core_gnt,
  output logic [N_CORES-1:0]                core_rvalid,
  output logic [N_CORES-1:0][DATA_W-1:0]    core_rdata,
  output logic [N_BANKS-1:0]                bank_req,
  output logic [N_BANKS-1:0][BANK_AW-1:0]   bank_addr,
  input  logic [N_BANKS-1:0][DATA_W-1:0]    bank_rdata
);

  // Requests are masked during reset so nothing is granted while rst_n is low.
  logic [N_CORES-1:0] req_eff;
  assign req_eff = core_req & {N_CORES{rst_n}};

  logic [BIDX_W-1:0]  core_bidx  [N_CORES];
  logic [BANK_AW-1:0] core_waddr [N_CORES];

  always_comb begin
    for (int c = 0; c < N_CORES; c++) begin
      core_bidx[c]  = BIDX_W'(core_addr[c] >> 2);
      core_waddr[c] = BANK_AW'(core_addr[c] >> (2 + BIDX_W));
    end
  end

  logic [N_CORES-1:0] arb_req [N_BANKS];
  logic [N_CORES-1:0] arb_gnt [N_BANKS];
  logic [CID_W-1:0]   arb_id  [N_BANKS];

  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      arb_req[b] = '0;
      for (int c = 0; c < N_CORES; c++) begin
        arb_req[b][c] = req_eff[c] && (core_bidx[c] == BIDX_W'(b));
      end
    end
  end

  for (genvar gb = 0; gb < N_BANKS; gb++) begin : g_bank_arb
    rr_arbiter #(.N(N_CORES), .IDW(CID_W)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (arb_req[gb]),
      .gnt    (arb_gnt[gb]),
      .gnt_id (arb_id[gb])
    );
  end

  // A core targets a single bank, so OR-ing the per-bank grants is one-hot per core.
  always_comb begin
    core_gnt  = '0;
    bank_req  = '0;
    bank_addr = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      bank_req[b] = |arb_gnt[b];
      core_gnt    = core_gnt | arb_gnt[b];
      for (int c = 0; c < N_CORES; c++) begin
        if (arb_gnt[b][c]) begin
          bank_addr[b] = core_waddr[c];
        end
      end
    end
  end

  logic [N_BANKS-1:0] resp_vld;
  logic [CID_W-1:0]   resp_id [N_BANKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld <= '0;
      for (int b = 0; b < N_BANKS; b++) begin
        resp_id[b] <= '0;
      end
    end else begin
      resp_vld <= bank_req;
      for (int b = 0; b < N_BANKS; b++) begin
        resp_id[b] <= arb_id[b];
      end
    end
  end

  // Route each bank's data back to whichever core it served last cycle.
  always_comb begin
    core_rvalid = '0;
    core_rdata  = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int c = 0; c < N_CORES; c++) begin
        if (resp_vld[b] && (resp_id[b] == CID_W'(c))) begin
          core_rvalid[c] = 1'b1;
          core_rdata[c]  = bank_rdata[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_bank_xbar.sv
// tb/tb_imem_bank_xbar.sv - self-checking bench for imem_bank_xbar
module tb_imem_bank_xbar;

  localparam int NC  = 3;
  localparam int NB  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BAW = 28;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NC-1:0]            core_req;
  logic [NC-1:0][AW-1:0]    core_addr;
  logic [NC-1:0]            core_gnt;
  logic [NC-1:0]            core_rvalid;
  logic [NC-1:0][DW-1:0]    core_rdata;
  logic [NB-1:0]            bank_req;
  logic [NB-1:0][BAW-1:0]   bank_addr;
  logic [NB-1:0][DW-1:0]    bank_rdata;

  int vectors     = 0;
  int miscompares = 0;

  int            ptr [NB];
  logic [NC-1:0] prev_gnt;
  int            prev_bank [NC];
  bit            fix_rd = 1'b0;
  logic [31:0]   fix_val = '0;

  imem_bank_xbar dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_req    (core_req),
    .core_addr   (core_addr),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .bank_req    (bank_req),
    .bank_addr   (bank_addr),
    .bank_rdata  (bank_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] mk(input logic [1:0] bank, input logic [27:0] waddr);
    logic [1:0] lsb;
    lsb = 2'($urandom_range(0, 3));
    return {waddr, bank, lsb};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    prev_gnt = '0;
    for (int c = 0; c < NC; c++) prev_bank[c] = 0;
  endtask

  // One clock: drive at negedge, check outputs 1ns later, then advance the model.
  task automatic cycle(input logic [NC-1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2);
    logic [AW-1:0]  ad [NC];
    logic [NC-1:0]  eg;
    logic [NB-1:0]  eb;
    logic [BAW-1:0] ea [NB];
    logic [NC-1:0]  erv;
    logic [DW-1:0]  erd;
    int             win [NB];
    int             bestd;
    int             d;
    int             tb;
    @(negedge clk);
    ad[0] = a0; ad[1] = a1; ad[2] = a2;
    core_req = req;
    for (int c = 0; c < NC; c++) core_addr[c] = ad[c];
    for (int b = 0; b < NB; b++) bank_rdata[b] = fix_rd ? fix_val : $urandom;
    #1;
    eg = '0;
    eb = '0;
    for (int b = 0; b < NB; b++) begin
      win[b] = -1;
      ea[b]  = '0;
      bestd  = NC;
      if (rst_n) begin
        for (int c = 0; c < NC; c++) begin
          tb = int'((ad[c] / 4) % NB);
          if (req[c] && tb == b) begin
            d = (c - ptr[b] + NC) % NC;
            if (d < bestd) begin
              bestd  = d;
              win[b] = c;
            end
          end
        end
      end
      if (win[b] >= 0) begin
        eg[win[b]] = 1'b1;
        eb[b]      = 1'b1;
        ea[b]      = BAW'(ad[win[b]] / 16);
      end
    end
    chk("core_gnt", 64'(core_gnt), 64'(eg));
    chk("bank_req", 64'(bank_req), 64'(eb));
    for (int b = 0; b < NB; b++) chk($sformatf("bank_addr%0d", b), 64'(bank_addr[b]), 64'(ea[b]));
    erv = rst_n ? prev_gnt : '0;
    chk("core_rvalid", 64'(core_rvalid), 64'(erv));
    for (int c = 0; c < NC; c++) begin
      erd = erv[c] ? bank_rdata[prev_bank[c]] : '0;
      chk($sformatf("core_rdata%0d", c), 64'(core_rdata[c]), 64'(erd));
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int b = 0; b < NB; b++) if (win[b] >= 0) ptr[b] = (win[b] + 1) % NC;
      prev_gnt = eg;
      for (int c = 0; c < NC; c++) prev_bank[c] = int'((ad[c] / 4) % NB);
    end
  endtask

  initial begin
    logic [NC-1:0] seq2 [4];
    logic [NC-1:0] seq4 [5];
    logic [NC-1:0] r4;
    core_req   = '0;
    core_addr  = '0;
    bank_rdata = '0;
    model_reset();

    // Reset: requests are masked, everything idle.
    rst_n = 1'b0;
    cycle(3'b111, mk(2'd0, 28'd1), mk(2'd1, 28'd2), mk(2'd2, 28'd3));
    chk("rst_gnt", 64'(core_gnt), 64'd0);
    cycle(3'b000, '0, '0, '0);
    rst_n = 1'b1;

    // Single fetch with fixed data.
    fix_rd  = 1'b1;
    fix_val = 32'hDEAD_BEEF;
    cycle(3'b001, 32'h0000_0010, '0, '0);
    chk("t1_gnt", 64'(core_gnt), 64'b001);
    chk("t1_baddr", 64'(bank_addr[0]), 64'd1);
    cycle(3'b000, '0, '0, '0);
    chk("t1_rvalid", 64'(core_rvalid), 64'b001);
    chk("t1_rdata", 64'(core_rdata[0]), 64'hDEAD_BEEF);
    fix_rd = 1'b0;

    // Core 2 streams to bank 0, core 0 joins at the third cycle.
    seq4[0] = 3'b100; seq4[1] = 3'b100; seq4[2] = 3'b001; seq4[3] = 3'b100; seq4[4] = 3'b001;
    for (int i = 0; i < 5; i++) begin
      r4 = (i >= 2) ? 3'b101 : 3'b100;
      cycle(r4, mk(2'd0, 28'd7), '0, mk(2'd0, 28'(i)));
      chk($sformatf("t4_gnt%0d", i), 64'(core_gnt), 64'(seq4[i]));
    end

    // All three cores contend for bank 1; pointer wraps.
    seq2[0] = 3'b001; seq2[1] = 3'b010; seq2[2] = 3'b100; seq2[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      cycle(3'b111, mk(2'd1, 28'd10), mk(2'd1, 28'd11), mk(2'd1, 28'd12));
      chk($sformatf("t2_gnt%0d", i), 64'(core_gnt), 64'(seq2[i]));
    end

    // Distinct banks served in parallel.
    cycle(3'b111, 32'h04, 32'h08, 32'h0C);
    chk("t3_gnt", 64'(core_gnt), 64'b111);
    chk("t3_breq", 64'(bank_req), 64'b1110);
    cycle(3'b000, '0, '0, '0);
    chk("t3_rvalid", 64'(core_rvalid), 64'b111);

    // Asynchronous reset right after a grant drops the response and the pointer.
    cycle(3'b001, mk(2'd0, 28'd3), '0, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rvalid", 64'(core_rvalid), 64'd0);
    chk("t5_gnt", 64'(core_gnt), 64'd0);
    model_reset();
    cycle(3'b000, '0, '0, '0);
    rst_n = 1'b1;
    cycle(3'b000, '0, '0, '0);
    chk("t5_no_rv", 64'(core_rvalid), 64'd0);
    cycle(3'b011, mk(2'd0, 28'd4), mk(2'd0, 28'd5), '0);
    chk("t5_prio", 64'(core_gnt), 64'b001);

    // Core 1 loses bank 3 to core 0 and gives up.
    cycle(3'b011, mk(2'd3, 28'd5), mk(2'd3, 28'd6), '0);
    chk("t6_gnt", 64'(core_gnt), 64'b001);
    cycle(3'b000, '0, '0, '0);
    chk("t6_rv1", 64'(core_rvalid[1]), 64'd0);
    cycle(3'b011, mk(2'd3, 28'd5), mk(2'd3, 28'd6), '0);
    chk("t6_ptr3", 64'(core_gnt), 64'b010);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(3'($urandom_range(0, 7)),
            mk(2'($urandom_range(0, 3)), 28'($urandom)),
            mk(2'($urandom_range(0, 3)), 28'($urandom)),
            mk(2'($urandom_range(0, 3)), 28'($urandom)));
    end
    cycle(3'b000, '0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
